// File: rtl/ddr_frame_writer.sv
// ddr_frame_writer
//   Packs an 8-bit pixel byte stream into 64-bit words, holds them in a
//   BUF_DEPTH-word first-word-fall-through buffer and issues BURST_LEN-word
//   write commands to the DDR controller, starting at a host-programmed
//   64-byte aligned base address.
//
// Ports
//   clk, reset_clk     memory-controller user clock, sync active-high reset
//   capture_start      pulse, arms a frame capture (only from S_IDLE)
//   capture_abort      pulse, cancels capture and flushes the buffer
//   capture_addr       frame base byte address (64-byte aligned)
//   capture_count      frame length in bytes, rounded down to 64
//   pix_valid/pix_data pixel byte stream
//   mem_wr_req         write command request (held until mem_wr_ack)
//   mem_wr_addr        command word address in 8-byte units
//   mem_wr_ack         controller accepted the command
//   mem_wdata          buffer head word, zero when the buffer is empty
//   mem_wdata_rd       controller pops one word (honoured in S_DATA only)
//   capture_busy       high while a capture is in progress
//   capture_done       one-cycle pulse when the last burst has been popped
//   overflow           sticky, a word was dropped because the buffer was full
module ddr_frame_writer #(
    parameter int BUF_DEPTH = 32,
    parameter int BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        reset_clk,
    input  logic        capture_start,
    input  logic        capture_abort,
    input  logic [29:0] capture_addr,
    input  logic [23:0] capture_count,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic        mem_wr_req,
    output logic [23:0] mem_wr_addr,
    input  logic        mem_wr_ack,
    output logic [63:0] mem_wdata,
    input  logic        mem_wdata_rd,
    output logic        capture_busy,
    output logic        capture_done,
    output logic        overflow
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_REQ,
        S_DATA
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [63:0]   buf_mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic          buf_full;

    logic [63:0]   pack_word;
    logic [2:0]    lane;
    logic [23:0]   bytes_left;
    logic [23:0]   bytes_in;
    logic [CW-1:0] pop_cnt;
    logic [23:0]   frame_len;

    logic          take_byte;
    logic          word_done;
    logic          push;
    logic          pop;
    logic          burst_end;
    logic          done_nxt;
    logic          unused_bits;

    assign frame_len = {capture_count[23:6], 6'b0};

    // Address bits above the 24-bit word space, the sub-word byte offset, the
    // sub-burst count bits and the top packer lane are intentionally unused
    // (the 8th byte goes straight into the buffer word).
    assign unused_bits = ^{capture_addr[29:27], capture_addr[2:0],
                           capture_count[5:0], pack_word[63:56]};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count     = wr_ptr - rd_ptr;
    assign buf_full  = (count == PW'(BUF_DEPTH));

    assign take_byte = (state != S_IDLE) && pix_valid && (bytes_in != 24'd0);
    assign word_done = take_byte && (lane == 3'd7);
    assign push      = word_done && !buf_full;
    assign pop       = (state == S_DATA) && mem_wdata_rd && (count != '0);
    assign burst_end = pop && (pop_cnt == CW'(BURST_LEN - 1));

    assign mem_wdata = (count != '0) ? buf_mem[rd_ptr[AW-1:0]] : 64'd0;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (capture_start && (frame_len != 24'd0)) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (bytes_left == 24'd0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else if ((count >= PW'(BURST_LEN)) && !mem_wr_ack) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_wr_ack) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (burst_end) begin
                    state_nxt = S_FILL;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start.
        if (capture_abort) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            state        <= S_IDLE;
            mem_wr_req   <= 1'b0;
            mem_wr_addr  <= 24'd0;
            capture_busy <= 1'b0;
            capture_done <= 1'b0;
            overflow     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lane         <= 3'd0;
            bytes_left   <= 24'd0;
            bytes_in     <= 24'd0;
            pop_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            mem_wr_req   <= (state_nxt == S_REQ);
            capture_busy <= (state_nxt != S_IDLE);
            capture_done <= done_nxt;

            if (capture_abort) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                lane       <= 3'd0;
                bytes_left <= 24'd0;
                bytes_in   <= 24'd0;
                pop_cnt    <= '0;
            end else if (state == S_IDLE) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                lane    <= 3'd0;
                pop_cnt <= '0;
                if (capture_start) begin
                    mem_wr_addr <= capture_addr[26:3];
                    bytes_left  <= frame_len;
                    bytes_in    <= frame_len;
                    overflow    <= 1'b0;
                end
            end else begin
                if (take_byte) begin
                    bytes_in <= bytes_in - 24'd1;
                    lane     <= lane + 3'd1;
                end
                if (word_done) begin
                    if (buf_full) begin
                        overflow <= 1'b1;
                    end else begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end
                end
                if (pop) begin
                    rd_ptr  <= rd_ptr + PW'(1);
                    pop_cnt <= pop_cnt + CW'(1);
                end
                if ((state == S_REQ) && mem_wr_ack) begin
                    mem_wr_addr <= mem_wr_addr + 24'd8;
                    bytes_left  <= bytes_left - 24'd64;
                    pop_cnt     <= '0;
                end
            end
        end
    end

    // Datapath storage: no reset, contents are qualified by lane and count.
    always_ff @(posedge clk) begin
        if (take_byte) begin
            pack_word[{lane, 3'b000} +: 8] <= pix_data;
        end
        if (push) begin
            buf_mem[wr_ptr[AW-1:0]] <= {pix_data, pack_word[55:0]};
        end
    end

endmodule

// File: tb/tb_ddr_frame_writer.sv
// Self-checking bench for ddr_frame_writer: table of directed frames, hand
// sequences for overflow / abort / reset corners, and randomized frames
// checked against a byte-array reference model.
module tb_ddr_frame_writer;

    logic        clk = 1'b0;
    logic        reset_clk;
    logic        capture_start;
    logic        capture_abort;
    logic [29:0] capture_addr;
    logic [23:0] capture_count;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        mem_wr_req;
    logic [23:0] mem_wr_addr;
    logic        mem_wr_ack;
    logic [63:0] mem_wdata;
    logic        mem_wdata_rd;
    logic        capture_busy;
    logic        capture_done;
    logic        overflow;

    always #5 clk = ~clk;

    ddr_frame_writer #(.BUF_DEPTH(32), .BURST_LEN(8)) dut (
        .clk           (clk),
        .reset_clk     (reset_clk),
        .capture_start (capture_start),
        .capture_abort (capture_abort),
        .capture_addr  (capture_addr),
        .capture_count (capture_count),
        .pix_valid     (pix_valid),
        .pix_data      (pix_data),
        .mem_wr_req    (mem_wr_req),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_ack    (mem_wr_ack),
        .mem_wdata     (mem_wdata),
        .mem_wdata_rd  (mem_wdata_rd),
        .capture_busy  (capture_busy),
        .capture_done  (capture_done),
        .overflow      (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  frame_bytes [600];
    logic [63:0] exp_words   [80];

    typedef struct {
        logic [29:0] addr;
        logic [23:0] cnt;
        int          ack_dly;
        int          extras;
        bit          prefeed;
        int          bursts;
        logic [23:0] addr0;
    } frame_vec_t;

    frame_vec_t vecs [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: bytes fill 64-bit words little-endian, first byte in lane 0.
    task automatic build_model(input int nbytes, input bit rnd);
        for (int i = 0; i < nbytes; i++) begin
            frame_bytes[i] = rnd ? 8'($urandom()) : 8'(i);
        end
        for (int w = 0; w < nbytes / 8; w++) begin
            for (int k = 0; k < 8; k++) begin
                exp_words[w][8*k +: 8] = frame_bytes[8*w + k];
            end
        end
    endtask

    task automatic feed(input int first, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            pix_data  = frame_bytes[first + i];
            pix_valid = 1'b1;
            step();
            pix_valid = 1'b0;
        end
    endtask

    task automatic serve_burst(input logic [23:0] exp_addr, input int w0, input int ack_dly,
                               input int npops, input bit gaps);
        int k;
        k = 0;
        while (!mem_wr_req && k < 3000) begin
            step();
            k++;
        end
        check("req_seen", mem_wr_req, 1);
        check("req_addr", mem_wr_addr, exp_addr);
        for (int d = 0; d < ack_dly; d++) begin
            step();
            check("req_held", mem_wr_req, 1);
        end
        mem_wr_ack = 1'b1;
        step();
        mem_wr_ack = 1'b0;
        check("req_dropped", mem_wr_req, 0);
        check("addr_advanced", mem_wr_addr, 24'(exp_addr + 24'd8));
        for (int j = 0; j < npops; j++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            check("pop_data", mem_wdata, exp_words[w0 + j]);
            mem_wdata_rd = 1'b1;
            step();
            mem_wdata_rd = 1'b0;
        end
    endtask

    task automatic serve_frame(input int bursts, input logic [23:0] addr0, input int ack_dly,
                               input bit gaps, input bit expect_empty);
        int k;
        for (int b = 0; b < bursts; b++) begin
            serve_burst(24'(addr0 + 24'(8 * b)), 8 * b,
                        (ack_dly < 0) ? int'($urandom_range(0, 6)) : ack_dly, 8, gaps);
        end
        if (expect_empty) check("buf_empty_after_frame", mem_wdata, 0);
        k = 0;
        while (!capture_done && k < 8) begin
            step();
            k++;
        end
        check("done_pulse", capture_done, 1);
        check("busy_falls_with_done", capture_busy, 0);
        step();
        check("done_one_cycle", capture_done, 0);
        check("no_req_after_frame", mem_wr_req, 0);
    endtask

    task automatic start_frame(input logic [29:0] a, input logic [23:0] c);
        capture_addr  = a;
        capture_count = c;
        capture_start = 1'b1;
        step();
        capture_start = 1'b0;
    endtask

    task automatic run_frame(input logic [29:0] a, input logic [23:0] c, input int ack_dly,
                             input int extras, input bit prefeed, input int bursts,
                             input logic [23:0] addr0, input bit rnd);
        int flen;
        flen = int'(c / 24'd64) * 64;
        build_model(flen + extras, rnd);
        start_frame(a, c);
        check("busy_after_start", capture_busy, (bursts != 0));
        check("ovf_cleared", overflow, 0);
        if (bursts == 0) begin
            check("zero_len_no_done", capture_done, 0);
            feed(0, extras, 1'b0);
            check("zero_len_no_req", mem_wr_req, 0);
            check("zero_len_idle", capture_busy, 0);
            check("zero_len_no_done_late", capture_done, 0);
        end else if (prefeed) begin
            feed(0, flen + extras, 1'b1);
            serve_frame(bursts, addr0, ack_dly, 1'b1, 1'b1);
        end else begin
            fork
                feed(0, flen + extras, 1'b1);
                serve_frame(bursts, addr0, ack_dly, 1'b1, 1'b0);
            join
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},      mem_wr_req, 0);
        check({tag, "_addr"},     mem_wr_addr, 0);
        check({tag, "_wdata"},    mem_wdata, 0);
        check({tag, "_busy"},     capture_busy, 0);
        check({tag, "_done"},     capture_done, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    initial begin
        logic [29:0] ra;
        logic [23:0] rc;
        int          k;

        reset_clk     = 1'b1;
        capture_start = 1'b0;
        capture_abort = 1'b0;
        capture_addr  = '0;
        capture_count = '0;
        pix_valid     = 1'b0;
        pix_data      = '0;
        mem_wr_ack    = 1'b0;
        mem_wdata_rd  = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        reset_clk = 1'b0;
        step();

        //           addr            count   dly extras pre bursts addr0
        vecs[0] = '{30'h0000_0100, 24'd64,  0,  0,  1'b0, 1, 24'h000020};
        vecs[1] = '{30'h0000_4000, 24'd256, 5,  0,  1'b0, 4, 24'h000800};
        vecs[2] = '{30'h0000_0200, 24'd100, 1,  36, 1'b1, 1, 24'h000040};
        vecs[3] = '{30'h3FFF_FFC0, 24'd128, 2,  5,  1'b0, 2, 24'hFFFFF8};
        vecs[4] = '{30'h0000_0400, 24'd63,  0,  8,  1'b0, 0, 24'h000080};
        vecs[5] = '{30'h0001_2340, 24'd255, 3,  3,  1'b0, 3, 24'h002468};
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].addr, vecs[i].cnt, vecs[i].ack_dly, vecs[i].extras,
                      vecs[i].prefeed, vecs[i].bursts, vecs[i].addr0, 1'b0);
        end

        // Start and abort together: abort wins.
        capture_addr  = 30'h100;
        capture_count = 24'd64;
        capture_start = 1'b1;
        capture_abort = 1'b1;
        step();
        capture_start = 1'b0;
        capture_abort = 1'b0;
        check("collide_busy", capture_busy, 0);
        step();
        check("collide_still_idle", capture_busy, 0);

        // Overflow: controller holds off, 33rd word is dropped.
        build_model(264, 1'b1);
        start_frame(30'h0, 24'd512);
        feed(0, 256, 1'b0);
        check("ovf_not_yet", overflow, 0);
        check("ovf_req_pending", mem_wr_req, 1);
        check("ovf_head_word", mem_wdata, exp_words[0]);
        feed(256, 8, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_head_unchanged", mem_wdata, exp_words[0]);
        for (int b = 0; b < 4; b++) begin
            serve_burst(24'(8 * b), 8 * b, 0, 8, 1'b0);
        end
        check("ovf_dropped_word_absent", mem_wdata, 0);
        check("ovf_sticky", overflow, 1);
        check("ovf_still_busy", capture_busy, 1);
        capture_abort = 1'b1;
        step();
        capture_abort = 1'b0;
        check("ovf_abort_idle", capture_busy, 0);
        check("ovf_held_after_abort", overflow, 1);

        // Abort in the middle of a data phase after 3 pops.
        build_model(128, 1'b1);
        start_frame(30'h1000, 24'd128);
        check("ovf_cleared_by_start", overflow, 0);
        feed(0, 128, 1'b0);
        serve_burst(24'h200, 0, 2, 3, 1'b0);
        capture_abort = 1'b1;
        step();
        capture_abort = 1'b0;
        check("abort_busy", capture_busy, 0);
        check("abort_req", mem_wr_req, 0);
        check("abort_buf_flushed", mem_wdata, 0);
        check("abort_no_done", capture_done, 0);
        step();
        check("abort_no_done_late", capture_done, 0);
        run_frame(30'h1000, 24'd128, 1, 0, 1'b0, 2, 24'h200, 1'b1);

        // Reset while a request is pending; start is ignored during reset.
        build_model(64, 1'b0);
        start_frame(30'h40, 24'd64);
        feed(0, 64, 1'b0);
        k = 0;
        while (!mem_wr_req && k < 100) begin
            step();
            k++;
        end
        check("rst_req_pending", mem_wr_req, 1);
        check("rst_req_addr", mem_wr_addr, 24'h8);
        reset_clk     = 1'b1;
        capture_start = 1'b1;
        step();
        check_reset_values("midreq_reset");
        step();
        check("start_ignored_in_reset", capture_busy, 0);
        reset_clk     = 1'b0;
        capture_start = 1'b0;
        step();
        check("after_reset_idle", capture_busy, 0);
        check("after_reset_no_req", mem_wr_req, 0);

        // Randomized frames.
        for (int r = 0; r < 8; r++) begin
            ra = 30'($urandom()) & 30'h3FFF_FFC0;
            rc = 24'($urandom_range(64, 319));
            run_frame(ra, rc, -1, int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
                      int'(rc) / 64, 24'(ra / 30'd8), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
